// File: rtl/board_frame_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | board_frame_tx_if : byte link from the frame sender to the host      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface board_frame_tx_if;
    logic       out_tx_valid;
    logic [7:0] out_tx_data;
    logic       in_tx_ready;

    modport master (output out_tx_valid, output out_tx_data, input in_tx_ready);
    modport slave  (input out_tx_valid, input out_tx_data, output in_tx_ready);
endinterface
`default_nettype wire

// File: rtl/board_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | board_frame_tx : captures displayed cells and sends the board as a   |
// | header/cells/status byte frame on each display-done. Rev 1.0         |
// +----------------------------------------------------------------------+
module board_frame_tx #(
    parameter int         NCELLS   = 25,
    parameter int         IDX_W    = 5,
    parameter int         CNT_W    = 3,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  wire               in_clka,
    input  wire               in_restart_n,
    input  wire               in_display,
    input  wire               in_display_done,
    input  wire [IDX_W-1:0]   in_temp_index,
    input  wire [CNT_W-1:0]   in_temp_mine_cnt,
    input  wire [NCELLS-1:0]  in_temp_cleared,
    input  wire               in_gameover,
    input  wire               in_win,
    board_frame_tx_if.master  tx,
    output logic              out_busy,
    output logic              out_frame_done,
    output logic              out_overflow
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_HDR     = 3'd2;
    localparam logic [2:0] S_CELLS   = 3'd3;
    localparam logic [2:0] S_STAT    = 3'd4;

    localparam logic [IDX_W:0]   c_NCELLS = (IDX_W+1)'(NCELLS);
    localparam logic [IDX_W-1:0] c_LAST   = IDX_W'(NCELLS-1);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [1:0]       flags_q, flags_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;
    logic [3:0]       cells_q [NCELLS];

    logic             w_busy, w_idx_ok, w_wr_en, w_accept, w_last;
    logic [2:0]       w_cnt3;
    logic [IDX_W-1:0] w_nxt_idx;

    // Stored cell is {cleared, count[2:0]}; the low nibble of the byte is always zero.
    generate
        if (CNT_W >= 3) begin : g_cnt_trunc
            assign w_cnt3 = in_temp_mine_cnt[2:0];
        end else begin : g_cnt_ext
            assign w_cnt3 = {{(3-CNT_W){1'b0}}, in_temp_mine_cnt};
        end
    endgenerate

    assign w_busy    = (state_q == S_HDR) || (state_q == S_CELLS) || (state_q == S_STAT);
    assign w_idx_ok  = {1'b0, in_temp_index} < c_NCELLS;
    assign w_wr_en   = in_display && !w_busy && w_idx_ok;
    assign w_accept  = valid_q && tx.in_tx_ready;
    assign w_last    = (cnt_q == c_LAST);
    assign w_nxt_idx = cnt_q + 1'b1;

    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            flags_q      <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flags_q      <= flags_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) begin
            for (int i = 0; i < NCELLS; i++) begin
                cells_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            cells_q[in_temp_index] <= {in_temp_cleared[in_temp_index], w_cnt3};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_display_done)  state_d = S_HDR;
                else if (in_display)  state_d = S_CAPTURE;
            end
            S_CAPTURE: if (in_display_done) state_d = S_HDR;
            S_HDR:     if (w_accept) state_d = S_CELLS;
            S_CELLS:   if (w_accept && w_last) state_d = S_STAT;
            S_STAT:    if (w_accept) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Next byte is loaded on acceptance so data stays stable while stalled.
    always_comb begin
        cnt_d        = cnt_q;
        flags_d      = flags_q;
        valid_d      = valid_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q | (in_display && (w_busy || !w_idx_ok));
        case (state_q)
            S_IDLE, S_CAPTURE: begin
                if (in_display_done) begin
                    flags_d = {in_gameover, in_win};
                    valid_d = 1'b1;
                    data_d  = HDR_BYTE;
                    cnt_d   = '0;
                end
            end
            S_HDR: begin
                if (w_accept) begin
                    cnt_d  = '0;
                    data_d = {cells_q[0], 4'b0000};
                end
            end
            S_CELLS: begin
                if (w_accept) begin
                    if (w_last) begin
                        data_d = {6'b000000, flags_q};
                    end else begin
                        cnt_d  = w_nxt_idx;
                        data_d = {cells_q[w_nxt_idx], 4'b0000};
                    end
                end
            end
            S_STAT: begin
                if (w_accept) begin
                    valid_d      = 1'b0;
                    data_d       = '0;
                    frame_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign tx.out_tx_valid = valid_q;
    assign tx.out_tx_data  = data_q;
    assign out_busy        = w_busy;
    assign out_frame_done  = frame_done_q;
    assign out_overflow    = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_board_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_board_frame_tx : directed + randomized bench with board model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_board_frame_tx;
    localparam int NC = 25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp = 1'b0, done = 1'b0, go = 1'b0, win = 1'b0;
    logic [4:0]  idx = '0;
    logic [2:0]  cnt = '0;
    logic [24:0] clr = '0;
    logic        busy, fdone, ovf;

    board_frame_tx_if tx_if();

    board_frame_tx dut (
        .in_clka          (clk),
        .in_restart_n     (rst_n),
        .in_display       (disp),
        .in_display_done  (done),
        .in_temp_index    (idx),
        .in_temp_mine_cnt (cnt),
        .in_temp_cleared  (clr),
        .in_gameover      (go),
        .in_win           (win),
        .tx               (tx_if),
        .out_busy         (busy),
        .out_frame_done   (fdone),
        .out_overflow     (ovf)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         m_clr [NC];
    int         m_cnt [NC];
    bit         m_ovf;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_clr[i] = 0;
            m_cnt[i] = 0;
        end
        m_ovf = 1'b0;
    endtask

    task automatic build_frame(input int bgo, input int bwin);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < NC; i++) exp_q.push_back(8'(m_clr[i] * 128 + (m_cnt[i] % 8) * 16));
        exp_q.push_back(8'(bgo * 2 + bwin));
    endtask

    // One idle-state cycle: optional beat, optional done; model follows the board rules.
    task automatic drive(input int do_beat, input int bi, input int bc, input int bclr,
                         input int do_done, input int bgo, input int bwin);
        logic [31:0] r;
        r    = $urandom;
        disp = 1'(do_beat);
        idx  = 5'(bi);
        cnt  = 3'(bc);
        clr  = r[24:0];
        if (bi < NC) clr[bi] = 1'(bclr);
        done = 1'(do_done);
        go   = 1'(bgo);
        win  = 1'(bwin);
        if (do_beat != 0) begin
            if (bi < NC) begin
                m_clr[bi] = bclr;
                m_cnt[bi] = bc;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (do_done != 0) build_frame(bgo, bwin);
        tick();
        disp = 1'b0;
        done = 1'b0;
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0, 2: random ready
    task automatic recv_frame(input int mode, input int inj_at, input int limit);
        int         n = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        bit         inj = 1'b0;
        bit         rdy;
        logic [7:0] held = '0;
        chk("valid_rise", tx_if.out_tx_valid, 1);
        chk("busy_rise", busy, 1);
        while (n < limit && cyc < 500) begin
            if (stalled) begin
                chk("stall_valid", tx_if.out_tx_valid, 1);
                chk("stall_data", tx_if.out_tx_data, held);
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            if (inj_at >= 0 && n == inj_at && !inj) begin
                disp = 1'b1; idx = 5'd3; cnt = 3'd7; clr = '1;
                done = 1'b1; go = 1'b1; win = 1'b1;
                inj = 1'b1;
                m_ovf = 1'b1;
            end
            tx_if.in_tx_ready = rdy;
            if (tx_if.out_tx_valid && rdy) begin
                chk($sformatf("byte%0d", n), tx_if.out_tx_data, exp_q[n]);
                n++;
                stalled = 1'b0;
            end else begin
                stalled = tx_if.out_tx_valid;
                held    = tx_if.out_tx_data;
            end
            tick();
            disp = 1'b0;
            done = 1'b0;
            cyc++;
        end
        tx_if.in_tx_ready = 1'b0;
        chk("frame_len", n, limit);
        if (limit == NC + 2) begin
            chk("fdone_pulse", fdone, 1);
            chk("valid_drop", tx_if.out_tx_valid, 0);
            chk("busy_drop", busy, 0);
            tick();
            chk("fdone_clear", fdone, 0);
            chk("overflow", ovf, m_ovf);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_if.in_tx_ready = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_valid", tx_if.out_tx_valid, 0);
        chk("rst_data", tx_if.out_tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fdone", fdone, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        // Done with no beats since reset: empty board, win status.
        drive(0, 0, 0, 0, 1, 0, 1);
        recv_frame(0, -1, NC + 2);

        // Full pass, cleared everywhere, count = idx % 8.
        for (int i = 0; i < NC; i++) drive(1, i, i % 8, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        recv_frame(0, -1, NC + 2);

        // Same pass with a stalling host.
        for (int i = 0; i < NC; i++) drive(1, i, i % 8, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        recv_frame(1, -1, NC + 2);

        // Beat coinciding with done lands in this frame.
        drive(1, 6, 2, 1, 1, 0, 0);
        recv_frame(0, -1, NC + 2);

        // Out-of-range index, then a beat plus done injected mid-frame.
        drive(1, 27, 5, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        recv_frame(0, 5, NC + 2);
        drive(0, 0, 0, 0, 1, 0, 0);
        recv_frame(2, -1, NC + 2);

        // Asynchronous reset after 10 accepted bytes.
        drive(0, 0, 0, 0, 1, 1, 1);
        recv_frame(1, -1, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", tx_if.out_tx_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_fdone", fdone, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(0, 0, 0, 0, 1, 1, 1);
        recv_frame(0, -1, NC + 2);

        // Randomized passes.
        for (int p = 0; p < 6; p++) begin
            int nb;
            int bi;
            int same;
            nb   = $urandom_range(1, 40);
            same = $urandom_range(0, 1);
            for (int b = 0; b < nb; b++) begin
                bi = ($urandom_range(0, 15) == 0) ? $urandom_range(25, 31) : $urandom_range(0, 24);
                drive(1, bi, $urandom_range(0, 7), $urandom_range(0, 1),
                      (same != 0 && b == nb - 1) ? 1 : 0,
                      $urandom_range(0, 1), $urandom_range(0, 1));
            end
            if (same == 0) drive(0, 0, 0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 1));
            recv_frame(2, -1, NC + 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
